// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default reset PC, MIPS field
// slices, the no-op word and the {PC, word} entry held by the fetch queue.
package instr_fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // Sequential fetch wraps 32'hFFFF_FFFC -> 0 through plain modular addition.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous FIFO of DEPTH {PC, word} entries with push, pop and flush;
// flush (and reset) empty the queue and take priority over push and pop.
module instr_fetch_unit_fetch_queue
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; entries are only read once count says they were written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch front end: issues in-order word fetches under a DEPTH credit limit,
// queues returned words and hands them to decode; a redirect flushes and drops
// stale responses. Optional IFU_BYPASS_EN forwards a response straight to decode.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        IMemReqValid,
   input  logic        IMemReqReady,
   output logic [31:0] IMemAddr,
   input  logic        IMemRespValid,
   input  logic [31:0] IMemRData,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC,
   output logic [5:0]  Op,
   output logic [5:0]  Funct,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC
);

   localparam int             CW  = $clog2(DEPTH+1);
   localparam logic [CW:0]    CAP = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] in_flight;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [CW:0]   credits_used;
   logic          q_full;
   logic          q_empty;
   logic          q_push;
   logic          q_pop;
   logic          req_fire;
   logic          resp_drop;
   logic          resp_keep;
   logic          bypass_take;
   logic          out_valid;
   logic [31:0]   resp_pc;
   fetch_entry_t  resp_entry;
   fetch_entry_t  q_head;
   fetch_entry_t  out_entry;

   assign credits_used = {1'b0, count} + {1'b0, in_flight};
   assign IMemReqValid = !reset && !Redirect && (credits_used < CAP);
   assign IMemAddr     = fetch_pc;
   assign req_fire     = IMemReqValid && IMemReqReady;

   assign resp_drop = IMemRespValid && (drop_cnt != '0);
   assign resp_keep = IMemRespValid && (drop_cnt == '0) && !Redirect;

   // Live requests are consecutive words, so the oldest one sits in_flight words behind fetch_pc.
   assign resp_pc    = fetch_pc - (32'(in_flight) << 2);
   assign resp_entry = '{pc: resp_pc, word: IMemRData};

`ifdef IFU_BYPASS_EN
   assign bypass_take = resp_keep && q_empty;
`else
   assign bypass_take = 1'b0;
`endif

   assign out_valid = !reset && (!q_empty || bypass_take);
   assign out_entry = q_empty ? resp_entry : q_head;
   assign q_pop     = InstrReady && !q_empty && !Redirect && !reset;
   assign q_push    = resp_keep && !(bypass_take && InstrReady);

   assign InstrValid = out_valid;
   assign Instr      = out_valid ? out_entry.word : INSTR_NOP;
   assign InstrPC    = out_valid ? out_entry.pc : 32'h0;
   assign Op         = Instr[OP_MSB:OP_LSB];
   assign Funct      = Instr[FUNCT_MSB:FUNCT_LSB];

   instr_fetch_unit_fetch_queue #(
      .DEPTH(DEPTH)
   ) u_fetch_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (Redirect),
      .push      (q_push),
      .push_data (resp_entry),
      .pop       (q_pop),
      .head      (q_head),
      .count     (count),
      .full      (q_full),
      .empty     (q_empty)
   );

   // NOTE: state uses non-blocking assignments so every update sees last cycle's values.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc  <= RESET_PC;
         in_flight <= '0;
         drop_cnt  <= '0;
      end else begin
         in_flight <= in_flight + CW'(req_fire) - CW'(IMemRespValid);
         if (Redirect) begin
            fetch_pc <= word_align(RedirectPC);
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_cnt <= in_flight - CW'(IMemRespValid);
         end else begin
            if (req_fire) fetch_pc <= next_pc(fetch_pc);
            drop_cnt <= drop_cnt - CW'(resp_drop);
         end
      end
   end

   assert property (@(posedge clk) disable iff (reset) !(q_push && q_full))
      else $error("instr_fetch_unit: push into full fetch queue");

endmodule
